// File: rtl/booth_mul_seq_if.sv
// Handshake bundle between the ALU controller (master) and the Booth multiplier (slave).
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one shared adder, WIDTH+1 iterations,
// signed or unsigned operands chosen per operation, product held until the next accept.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    booth_mul_seq_if.slave  bus
);
    // Operands are extended by one bit so unsigned values behave as positive
    // signed numbers; the accumulator gets one more bit so A - M never overflows.
    localparam int EW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [EW-1:0]      m_q, m_d;
    logic [EW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [AW-1:0]      a_q, a_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [AW-1:0]      m_sx;
    logic [AW-1:0]      addend;
    logic               cin;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      a_sh;
    logic [EW-1:0]      q_sh;

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {A, Q, q_-1}.
    always_comb begin
        m_sx   = {m_q[EW-1], m_q};
        addend = '0;
        cin    = 1'b0;
        case ({q_q[0], qm1_q})
            2'b01:   addend = m_sx;
            2'b10: begin
                addend = ~m_sx;
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        sum  = a_q + addend + AW'(cin);
        a_sh = {sum[AW-1], sum[AW-1:1]};
        q_sh = {sum[0], q_q[EW-1:1]};
    end

    // Next-state logic: accept from IDLE/DONE, iterate in RUN, present the product in DONE.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_RUN: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    // Low 2*WIDTH bits of {A, Q} after the final shift.
                    product_d = {a_sh[WIDTH-2:0], q_sh};
                end
            end
            default: begin
                if (bus.start) begin
                    m_d     = bus.signed_mode ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                                              : {1'b0, bus.multiplicand};
                    q_d     = bus.signed_mode ? {bus.multiplier[WIDTH-1], bus.multiplier}
                                              : {1'b0, bus.multiplier};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(WIDTH + 1);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            a_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: a 32-bit instance for directed vectors and
// handshake/reset behaviour, and a 4-bit instance swept over every operand pair.
module tb_booth_mul_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [63:0] exp32_q[$];
    logic [7:0]  exp4_q[$];

    booth_mul_seq_if #(.WIDTH(32)) b32 ();
    booth_mul_seq_if #(.WIDTH(4))  b4 ();

    booth_mul_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    booth_mul_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
        else $display("ok   %s = %h", name, got);
    endtask

    // Monitor for the 32-bit instance: every done pops one expected product.
    always @(negedge clk) begin
        if (!rst) begin
            if (b32.busy && b32.done) begin
                errors++;
                $display("FAIL busy_done_overlap32 got busy=1 done=1 required not both");
            end
            if (b32.done) begin
                checks++;
                if (exp32_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done32 got done with product %h required no done", b32.product);
                end else begin
                    logic [63:0] e;
                    e = exp32_q.pop_front();
                    if (b32.product !== e) begin
                        errors++;
                        $display("FAIL product32 got %h required %h", b32.product, e);
                    end
                    else $display("ok   product32 = %h", b32.product);
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (b4.busy && b4.done) begin
                errors++;
                $display("FAIL busy_done_overlap4 got busy=1 done=1 required not both");
            end
            if (b4.done) begin
                checks++;
                if (exp4_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done4 got done with product %h required no done", b4.product);
                end else begin
                    logic [7:0] e;
                    e = exp4_q.pop_front();
                    if (b4.product !== e) begin
                        errors++;
                        $display("FAIL product4 got %h required %h", b4.product, e);
                    end
                end
            end
        end
    end

    // Drive one start pulse on the 32-bit instance; returns just after the accepting edge.
    task automatic issue32(input logic [31:0] m, input logic [31:0] q, input logic s,
                           input bit push, input logic [63:0] want);
        @(negedge clk);
        b32.start        = 1'b1;
        b32.signed_mode  = s;
        b32.multiplicand = m;
        b32.multiplier   = q;
        if (push) exp32_q.push_back(want);
        @(posedge clk);
        #1;
        b32.start = 1'b0;
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b32.done) return;
        end
        errors++;
        $display("FAIL timeout32 got no done required done within 200 cycles");
        lat = -1;
    endtask

    task automatic issue4(input logic [3:0] m, input logic [3:0] q, input logic s);
        logic [31:0] am, aq;
        @(negedge clk);
        b4.start        = 1'b1;
        b4.signed_mode  = s;
        b4.multiplicand = m;
        b4.multiplier   = q;
        // Reference: extend each operand to 32 bits per mode, multiply, keep 8 bits.
        am = s ? {{28{m[3]}}, m} : {28'b0, m};
        aq = s ? {{28{q[3]}}, q} : {28'b0, q};
        exp4_q.push_back(8'(am * aq));
        @(posedge clk);
        #1;
        b4.start = 1'b0;
    endtask

    task automatic wait_done4(output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b4.done) return;
        end
        errors++;
        $display("FAIL timeout4 got no done required done within 50 cycles");
        lat = -1;
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b32.start = 1'b0; b32.signed_mode = 1'b0; b32.multiplicand = '0; b32.multiplier = '0;
        b4.start  = 1'b0; b4.signed_mode  = 1'b0; b4.multiplicand  = '0; b4.multiplier  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("reset_busy32", 64'(b32.busy), 64'd0);
        chk("reset_done32", 64'(b32.done), 64'd0);
        chk("reset_product32", b32.product, 64'd0);
        chk("reset_product4", 64'(b4.product), 64'd0);

        // Directed 32-bit vectors.
        issue32(32'd7, 32'hFFFFFFFD, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEB);
        wait_done32(lat);
        chk("latency32", 64'(lat), 64'd33);
        chk("busy_at_done32", 64'(b32.busy), 64'd0);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE00000001);
        wait_done32(lat);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001);
        wait_done32(lat);
        issue32(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);
        wait_done32(lat);
        issue32(32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF80000000);
        wait_done32(lat);
        issue32(32'h80000000, 32'h80000000, 1'b0, 1'b1, 64'h4000000000000000);
        wait_done32(lat);
        issue32(32'h0000FFFF, 32'h00010001, 1'b0, 1'b1, 64'h00000000FFFFFFFF);
        wait_done32(lat);

        // start pulses while busy are ignored: one done, product 30.
        issue32(32'd5, 32'd6, 1'b0, 1'b1, 64'd30);
        repeat (2) @(posedge clk);
        #1;
        b32.start = 1'b1; b32.multiplicand = 32'd9; b32.multiplier = 32'd9;
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        b32.start = 1'b1;
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        wait_done32(lat);
        repeat (5) @(posedge clk);
        #1;
        chk("product_held32", b32.product, 64'd30);

        // start held high: operand changes while busy are ignored; second op accepted on done cycle.
        @(negedge clk);
        b32.start = 1'b1; b32.signed_mode = 1'b0;
        b32.multiplicand = 32'd3; b32.multiplier = 32'd4;
        exp32_q.push_back(64'd12);
        exp32_q.push_back(64'd20000);
        @(posedge clk);
        #1;
        b32.multiplicand = 32'd100; b32.multiplier = 32'd200;
        wait_done32(lat);
        chk("held_first_latency32", 64'(lat), 64'd33);
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        chk("b2b_accept_busy32", 64'(b32.busy), 64'd1);
        wait_done32(lat);
        chk("b2b_latency32", 64'(lat), 64'd33);

        // Reset mid-operation: aborted, no done, product cleared.
        issue32(32'd1234, 32'd5678, 1'b0, 1'b0, 64'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy32", 64'(b32.busy), 64'd0);
        chk("rst_done32", 64'(b32.done), 64'd0);
        chk("rst_product32", b32.product, 64'd0);
        repeat (40) @(posedge clk);
        chk("rst_pending32", 64'(exp32_q.size()), 64'd0);
        issue32(32'd1234, 32'd5678, 1'b0, 1'b1, 64'd7006652);
        wait_done32(lat);
        chk("post_rst_latency32", 64'(lat), 64'd33);

        // Exhaustive 4-bit sweep, both modes.
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 16; m++) begin
                for (int q = 0; q < 16; q++) begin
                    issue4(4'(m), 4'(q), 1'(s));
                    wait_done4(lat);
                    if (s == 0 && m == 0 && q == 0) chk("latency4", 64'(lat), 64'd5);
                end
            end
        end
        repeat (3) @(posedge clk);
        chk("pending4", 64'(exp4_q.size()), 64'd0);
        chk("pending32", 64'(exp32_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
